// File: rtl/seg7_bcd_display.sv
// 16-bit binary to five-digit BCD converter (sequential double-dabble) driving an
// eight-digit multiplexed seven-segment display with optional leading-zero blanking.
module seg7_bcd_display #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] value_i,
    output logic [7:0]  seg_o,
    output logic [7:0]  an_o,
    output logic        busy_o,
    output logic [19:0] bcd_o
);

    localparam int unsigned    CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e      state_q;
    logic [15:0] shift_q;
    logic [19:0] scratch_q;
    logic [3:0]  iter_q;
    logic [15:0] cap_q;
    logic [15:0] last_q;
    logic [19:0] bcd_q;
    logic        busy_q;

    logic [19:0] adj;

    logic [CW-1:0] scan_q, scan_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;

    logic [3:0] dig [8];
    logic [7:0] lead_zero;

    // Add-3 correction on every nibble, applied ahead of each shift.
    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                              ? scratch_q[4*gi +: 4] + 4'd3
                              : scratch_q[4*gi +: 4];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            cap_q     <= '0;
            last_q    <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (value_i != last_q) begin
                        cap_q     <= value_i;
                        shift_q   <= value_i;
                        scratch_q <= '0;
                        iter_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {scratch_q, shift_q} <= {adj, shift_q} << 1;
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'd15) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_q   <= scratch_q;
                    last_q  <= cap_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Slots 5..7 have no digit; they read as a permanently blank leading zero.
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        if (gi < 5) begin : g_real
            assign dig[gi]       = bcd_q[4*gi +: 4];
            assign lead_zero[gi] = (bcd_q[19:4*gi] == '0);
        end else begin : g_off
            assign dig[gi]       = 4'd0;
            assign lead_zero[gi] = 1'b1;
        end
    end

    function automatic logic [7:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    seg_pattern = 8'hC0;
            4'd1:    seg_pattern = 8'hF9;
            4'd2:    seg_pattern = 8'hA4;
            4'd3:    seg_pattern = 8'hB0;
            4'd4:    seg_pattern = 8'h99;
            4'd5:    seg_pattern = 8'h92;
            4'd6:    seg_pattern = 8'h82;
            4'd7:    seg_pattern = 8'hF8;
            4'd8:    seg_pattern = 8'h80;
            4'd9:    seg_pattern = 8'h90;
            default: seg_pattern = 8'hFF;
        endcase
    endfunction

    always_comb begin
        scan_d = scan_q + CW'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end
    end

    always_comb begin
        seg_d = 8'hFF;
        if (idx_q <= 3'd4 && !(BLANK_LZ && idx_q != 3'd0 && lead_zero[idx_q])) begin
            seg_d = seg_pattern(dig[idx_q]);
        end
        an_d = ~(8'b1 << idx_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scan_q <= '0;
            idx_q  <= '0;
            seg_q  <= 8'hFF;
            an_q   <= 8'hFF;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg_o  = seg_q;
    assign an_o   = an_q;
    assign busy_o = busy_q;
    assign bcd_o  = bcd_q;

endmodule

// File: doc/seg7_bcd_display.md
# seg7_bcd_display

Sequential display stage downstream of the CPU's 16-bit LED/scan output. Converts a 16-bit unsigned value to five BCD digits with a multi-cycle double-dabble engine, then time-multiplexes the eight on-board seven-segment digits. Replaces the combinational divide/modulo digit split with a registered, fixed-latency path.

## Interface
- SCAN_DIV, 100000: clock cycles per digit slot. Range 2..2^20.
- BLANK_LZ, 1: 1 blanks leading zeros on digits 1–4; digit 0 always shows.
- clock  in  1  system clock (CPU clk1 domain)
- rst  in  1  reset; asynchronous assert, active-low
- value  in  16  unsigned value to display, sampled by the converter
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered
- an_out  out  8  digit enables, one-hot active-low, bit 0 = rightmost, registered
- busy  out  1  high while a conversion is in progress
- bcd  out  20  committed display digits {d4,d3,d2,d1,d0}, 4 bits each

## Operation
- Converter FSM states:
  - IDLE: if value != last_done, capture value into shift register, clear BCD scratch, set bit counter to 0, and go to SHIFT. Otherwise stay.
  - SHIFT: one double-dabble iteration per cycle. Each BCD nibble ≥5 gets +3, then {scratch,shift} shifts left by 1. After 16 iterations go to DONE.
  - DONE: copy scratch to bcd, record captured value as last_done, return to IDLE.
- busy = 1 in SHIFT and DONE, 0 in IDLE.
- value changes while busy are ignored. IDLE re-compares on return, so the latest value always converts eventually.
- Scan counter:
  - Counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and digit index (3 bits) increments, wrapping 7→0.
- Digit decode for index i:
  - i = 5..7: blank.
  - i = 0..4: nibble bcd[4i+3:4i].
  - If BLANK_LZ=1 and i ≥ 1 and all digits d_i..d4 are 0: blank.
- Segment patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF. dp is always off.
- an_out = ~(8'b1 << index). seg_out is the pattern for that index.
- Reset (asynchronous, any state):
  - FSM → IDLE, scratch = 0, bcd = 0, last_done = 0, busy = 0.
  - Scan counter = 0, index = 0, seg_out = FF, an_out = FF.
  - A reset during SHIFT aborts the conversion; no partial result reaches bcd.

## Timing
- Conversion latency: value differs at edge N (IDLE captures) → 16 SHIFT cycles → DONE at edge N+17 → bcd valid after edge N+17. busy is high for cycles N+1..N+17.
- Back-to-back: the earliest next capture is at edge N+18.
- seg_out/an_out are registered one cycle after index or bcd changes. First post-reset update: an_out = FE, seg_out = C0 on the first edge after rst deasserts.
- Each digit is enabled for exactly SCAN_DIV cycles. Full refresh = 8×SCAN_DIV cycles.
- A bcd update in the middle of a slot takes effect on the next cycle, within the same slot. No glitch beyond one cycle.
- Width rules:
  - Scratch is 20 bits. Max input 65535 → d4..d0 = 6,5,5,3,5; no overflow.
  - Add-3 is applied before the shift, never after the 16th shift.

## Test plan
- Reset then release with value=0, SCAN_DIV=4 → within 1 cycle an_out=FE, seg_out=C0. Slots 1–7 show FF (leading zeros blanked, digits 5–7 off). busy stays 0.
- value=65535 → busy high exactly 17 cycles. bcd=0x65535. Over one 32-cycle refresh, digits 0..4 show 92,B0,92,92,82.
- value=1234 then value=7 changed mid-SHIFT → first bcd=0x01234, then a second conversion gives bcd=0x00007. No intermediate value ever appears.
- BLANK_LZ=0, value=50 → digits 4..0 show C0,C0,C0,92,C0. Digits 5–7 show FF.
- Assert rst at SHIFT iteration 8 of value=999 → bcd, busy, seg_out, an_out reset immediately (asynchronously). After release, 999 reconverts from scratch and yields bcd=0x00999.
- Random values (≥1000 samples) → bcd matches a decimal reference model. an_out is always one-hot low.
